// File: rtl/hive_pc_ring.sv
// Per-thread PC engine for the hive control ring: a two-stage update pipe
// commits each thread's next PC and irq state, and a round-robin fetch reads the PC array.
module hive_pc_ring #(
    parameter int THRD_W   = 3,
    parameter int PC_W     = 16,
    parameter int LEN_W    = 3,
    parameter int CLT_BASE = 'h0000,
    parameter int IRQ_BASE = 'h0040,
    parameter int VECT_SH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  vld_i,
    input  logic [THRD_W-1:0]     thd_i,
    input  logic [PC_W-1:0]       pc_i,
    input  logic                  clt_i,
    input  logic                  irq_i,
    input  logic                  irt_i,
    input  logic                  cnd_i,
    input  logic                  jmp_i,
    input  logic                  gto_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  imad_i,
    input  logic [PC_W-1:0]       im_pc_i,
    input  logic [PC_W-1:0]       b_i,
    input  logic                  flg_i,
    output logic [PC_W-1:0]       pc_o,
    output logic [THRD_W-1:0]     thd_o,
    output logic                  upd_vld_o,
    output logic [THRD_W-1:0]     upd_thd_o,
    output logic [PC_W-1:0]       rtn_o,
    output logic [(1<<THRD_W)-1:0] irq_act_o
);
    localparam int THRDS = 1 << THRD_W;

    typedef struct packed {
        logic [THRD_W-1:0] thd;
        logic [PC_W-1:0]   pc;
        logic              clt;
        logic              irq;
        logic              irt;
        logic              cnd;
        logic              jmp;
        logic              gto;
        logic [LEN_W-1:0]  len;
        logic              imad;
        logic [PC_W-1:0]   im_pc;
        logic [PC_W-1:0]   b;
        logic              flg;
    } bnd_t;

    bnd_t              s1;
    logic [2:1]        vld_pipe;
    logic [PC_W-1:0]   pc_q     [THRDS];
    logic [PC_W-1:0]   irq_pc_q [THRDS];
    logic [THRDS-1:0]  irq_act;
    logic [THRD_W-1:0] fth;

    logic [PC_W-1:0]   seq, off, vec_c, vec_i, nxt;
    logic              act_cur, act_nxt, irq_pc_we, taken;

    assign upd_vld_o = vld_pipe[2];
    assign irq_act_o = irq_act;

    // Stage-2 next-PC resolution, priority clt > irq > irt > gto > jmp > seq
    always_comb begin
        seq       = s1.pc + PC_W'(s1.len);
        off       = s1.imad ? s1.im_pc : s1.b;
        vec_c     = PC_W'(CLT_BASE) + (PC_W'(s1.thd) << VECT_SH);
        vec_i     = PC_W'(IRQ_BASE) + (PC_W'(s1.thd) << VECT_SH);
        act_cur   = irq_act[s1.thd];
        taken     = !s1.cnd || s1.flg;
        nxt       = seq;
        act_nxt   = act_cur;
        irq_pc_we = 1'b0;
        if (s1.clt) begin
            nxt     = vec_c;
            act_nxt = 1'b0;
        end else if (s1.irq) begin
            // A nested irq is dropped; the decoder's len=0 makes the thread re-execute
            if (!act_cur) begin
                nxt       = vec_i;
                act_nxt   = 1'b1;
                irq_pc_we = 1'b1;
            end
        end else if (s1.irt && act_cur) begin
            nxt     = irq_pc_q[s1.thd];
            act_nxt = 1'b0;
        end else if (s1.irt || s1.gto) begin
            nxt = s1.b;
        end else if (s1.jmp && taken) begin
            nxt = seq + off;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int t = 0; t < THRDS; t++) begin
                pc_q[t]     <= PC_W'(CLT_BASE) + (PC_W'(t) << VECT_SH);
                irq_pc_q[t] <= '0;
            end
            irq_act   <= '0;
            fth       <= '0;
            vld_pipe  <= '0;
            s1        <= '0;
            pc_o      <= '0;
            thd_o     <= '0;
            upd_thd_o <= '0;
            rtn_o     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], vld_i};
            if (vld_i)
                s1 <= '{thd: thd_i, pc: pc_i, clt: clt_i, irq: irq_i, irt: irt_i,
                        cnd: cnd_i, jmp: jmp_i, gto: gto_i, len: len_i, imad: imad_i,
                        im_pc: im_pc_i, b: b_i, flg: flg_i};
            if (vld_pipe[1]) begin
                pc_q[s1.thd]    <= nxt;
                irq_act[s1.thd] <= act_nxt;
                if (irq_pc_we)
                    irq_pc_q[s1.thd] <= s1.pc;
                upd_thd_o <= s1.thd;
                rtn_o     <= seq;
            end
            // Fetch sees a same-edge commit to its thread through the bypass
            fth   <= fth + 1'b1;
            thd_o <= fth;
            pc_o  <= (vld_pipe[1] && s1.thd == fth) ? nxt : pc_q[fth];
        end
    end
endmodule

// File: tb/tb_hive_pc_ring.sv
// Scoreboard bench for hive_pc_ring: stimulus pushes model results, a negedge
// monitor checks commits and every fetch against the committed-PC picture.
module tb_hive_pc_ring;
    localparam int THRD_W = 3, PC_W = 16, LEN_W = 3, THRDS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n_i, vld_i, clt_i, irq_i, irt_i, cnd_i, jmp_i, gto_i, imad_i, flg_i;
    logic [THRD_W-1:0] thd_i, thd_o, upd_thd_o;
    logic [PC_W-1:0]   pc_i, im_pc_i, b_i, pc_o, rtn_o;
    logic [LEN_W-1:0]  len_i;
    logic              upd_vld_o;
    logic [THRDS-1:0]  irq_act_o;

    hive_pc_ring dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .vld_i(vld_i), .thd_i(thd_i), .pc_i(pc_i),
        .clt_i(clt_i), .irq_i(irq_i), .irt_i(irt_i), .cnd_i(cnd_i), .jmp_i(jmp_i),
        .gto_i(gto_i), .len_i(len_i), .imad_i(imad_i), .im_pc_i(im_pc_i), .b_i(b_i),
        .flg_i(flg_i), .pc_o(pc_o), .thd_o(thd_o), .upd_vld_o(upd_vld_o),
        .upd_thd_o(upd_thd_o), .rtn_o(rtn_o), .irq_act_o(irq_act_o)
    );

    typedef struct {
        int              thd;
        logic [PC_W-1:0] rtn;
        logic [PC_W-1:0] nxt;
        logic [THRDS-1:0] act;
    } exp_t;

    exp_t q[$];
    int checks = 0, passed = 0;

    // reference state as the architecture sees it once every issued bundle is applied
    logic [PC_W-1:0]  m_pc [THRDS];
    logic [PC_W-1:0]  m_irq_pc [THRDS];
    logic [THRDS-1:0] m_act;
    // PCs the DUT should hold after the commits observed so far
    logic [PC_W-1:0]  cpc [THRDS];
    int exp_fth = 0;
    logic rst_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [PC_W-1:0] vec(input int base, input int t);
        return PC_W'((base + t * 4) % 65536);
    endfunction

    task automatic model_reset();
        for (int t = 0; t < THRDS; t++) begin
            m_pc[t] = vec(0, t);
            m_irq_pc[t] = '0;
        end
        m_act = '0;
    endtask

    always @(posedge clk) rst_seen <= rst_n_i;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_seen) begin
                chk("rst_pc_o", pc_o, 0);
                chk("rst_thd_o", thd_o, 0);
                chk("rst_upd_vld", upd_vld_o, 0);
                chk("rst_rtn", rtn_o, 0);
                chk("rst_irq_act", irq_act_o, 0);
                q.delete();
                for (int t = 0; t < THRDS; t++) cpc[t] = vec(0, t);
                exp_fth = 0;
            end else begin
                if (upd_vld_o) begin
                    if (q.size() == 0) chk("spurious_commit", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("upd_thd", upd_thd_o, e.thd);
                        chk("rtn", rtn_o, e.rtn);
                        chk("irq_act", irq_act_o, e.act);
                        cpc[e.thd] = e.nxt;
                    end
                end
                chk("fetch_thd", thd_o, exp_fth % THRDS);
                chk("fetch_pc", pc_o, cpc[thd_o]);
                exp_fth++;
            end
        end
    end

    task automatic idle(input int n);
        vld_i = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives one bundle for a cycle; with use_k the committed PC is the given constant
    task automatic issue(input int thd, input logic [PC_W-1:0] pc, input bit clt, irq, irt,
                         cnd, jmp, gto, input int len, input bit imad,
                         input logic [PC_W-1:0] im, b, input bit flg,
                         input bit use_k, input logic [PC_W-1:0] k);
        exp_t e;
        int s, n;
        vld_i = 1; thd_i = THRD_W'(thd); pc_i = pc; clt_i = clt; irq_i = irq; irt_i = irt;
        cnd_i = cnd; jmp_i = jmp; gto_i = gto; len_i = LEN_W'(len); imad_i = imad;
        im_pc_i = im; b_i = b; flg_i = flg;
        s = (int'(pc) + len) % 65536;
        n = s;
        if (clt) begin
            n = vec(0, thd); m_act[thd] = 0;
        end else if (irq) begin
            if (!m_act[thd]) begin
                m_irq_pc[thd] = pc; m_act[thd] = 1; n = vec('h40, thd);
            end
        end else if (irt && m_act[thd]) begin
            n = m_irq_pc[thd]; m_act[thd] = 0;
        end else if (irt || gto) begin
            n = b;
        end else if (jmp && (!cnd || flg)) begin
            n = (s + int'(imad ? im : b)) % 65536;
        end
        m_pc[thd] = PC_W'(n);
        e.thd = thd; e.rtn = PC_W'(s); e.nxt = use_k ? k : PC_W'(n); e.act = m_act;
        q.push_back(e);
        @(posedge clk); #1;
        vld_i = 0;
    endtask

    initial begin
        int guard;
        rst_n_i = 0; vld_i = 0; thd_i = 0; pc_i = 0; clt_i = 0; irq_i = 0; irt_i = 0;
        cnd_i = 0; jmp_i = 0; gto_i = 0; len_i = 0; imad_i = 0; im_pc_i = 0; b_i = 0; flg_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1;
        idle(12);

        issue(2, 'h0100, 0,0,0,0,0,0, 2, 0, 0, 0, 0, 1, 'h0102);           idle(4);
        issue(1, 'h0200, 0,0,0,1,1,0, 3, 1, 'hFFF0, 0, 1, 1, 'h01F3);      idle(4);
        issue(1, 'h0200, 0,0,0,1,1,0, 3, 1, 'hFFF0, 0, 0, 1, 'h0203);      idle(4);
        issue(4, 'hFFFE, 0,0,0,0,1,0, 4, 1, 'h0004, 0, 0, 1, 'h0006);      idle(4);
        issue(3, 'h0300, 0,1,0,0,0,0, 0, 0, 0, 0, 0, 1, 'h004C);           idle(4);
        issue(3, 'h0300, 0,1,0,0,0,0, 0, 0, 0, 0, 0, 1, 'h0300);           idle(4);
        issue(3, 'h004C, 0,0,1,0,0,0, 1, 0, 0, 'h1234, 0, 1, 'h0300);      idle(4);
        issue(5, 'h0500, 0,1,0,0,0,0, 0, 0, 0, 0, 0, 1, 'h0054);           idle(4);
        // align so the commit edge fetches thread 5 and the bypass path is exercised
        guard = 0;
        while ((exp_fth % THRDS) != 3 && guard < 16) begin @(posedge clk); #1; guard++; end
        chk("bypass_align", guard < 16, 1);
        issue(5, 'h0054, 1,1,0,0,1,0, 2, 1, 'h0100, 0, 1, 1, 'h0014);      idle(4);

        issue(6, 'h0600, 0,0,0,0,0,0, 1, 0, 0, 0, 0, 1, 'h0601);
        rst_n_i = 0;
        idle(2);
        rst_n_i = 1;
        model_reset();
        idle(10);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) begin
                int t;
                int r;
                logic [PC_W-1:0] p;
                t = $urandom_range(THRDS - 1);
                r = $urandom_range(15);
                p = $urandom_range(1) ? m_pc[t] : PC_W'($urandom);
                issue(t, p, r == 0, r == 1 || r == 2, r == 3 || r == 4, $urandom_range(1),
                      $urandom_range(1), $urandom_range(1), $urandom_range(7), $urandom_range(1),
                      PC_W'($urandom), PC_W'($urandom), $urandom_range(1), 0, 0);
            end else idle(1);
        end
        idle(4);
        chk("drain_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
